alu_exec_pipe: RTL and testbench

//  Parametrised, pipelined integer execute unit for the OoO core; successor to the single-cycle arithmetic stage.

---
 rtl/alu_exec_pipe_pkg.sv | 98 +++++++++
 rtl/alu_result_fifo.sv | 62 ++++++
 rtl/alu_exec_pipe.sv | 155 +++++++++++++++
 tb/tb_alu_exec_pipe.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_exec_pipe_pkg.sv
// Shared types, opcodes and combinational ALU/compare helpers for the pipelined execute unit.
package alu_exec_pipe_pkg;

  localparam int unsigned NO_PHY_REGS = 64;
  localparam int unsigned PHY_WIDTH   = $clog2(NO_PHY_REGS);
  localparam int unsigned ROB_IDX_W   = 5;
  localparam int unsigned XLEN        = 32;

  localparam logic [6:0] OP_REG   = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  typedef enum logic [2:0] {
    f3_add  = 3'b000,
    f3_sll  = 3'b001,
    f3_slt  = 3'b010,
    f3_sltu = 3'b011,
    f3_xor  = 3'b100,
    f3_sr   = 3'b101,
    f3_or   = 3'b110,
    f3_and  = 3'b111
  } funct3_t;

  // Encodings line up with funct3 for sll/xor/or/and so funct3 can be cast directly.
  typedef enum logic [2:0] {
    alu_add = 3'b000,
    alu_sll = 3'b001,
    alu_sra = 3'b010,
    alu_sub = 3'b011,
    alu_xor = 3'b100,
    alu_srl = 3'b101,
    alu_or  = 3'b110,
    alu_and = 3'b111
  } alu_ops_t;

  typedef enum logic [2:0] {
    cmp_beq  = 3'b000,
    cmp_bne  = 3'b001,
    cmp_blt  = 3'b100,
    cmp_bge  = 3'b101,
    cmp_bltu = 3'b110,
    cmp_bgeu = 3'b111
  } cmp_ops_t;

  typedef struct packed {
    logic [6:0]           opcode;
    logic [2:0]           funct3;
    logic [6:0]           funct7;
    logic [XLEN:0]        imm_val;
    logic [XLEN-1:0]      pc;
    logic [PHY_WIDTH-1:0] pr1_s;
    logic [PHY_WIDTH-1:0] pr2_s;
    logic [PHY_WIDTH-1:0] prd_s;
    logic [ROB_IDX_W-1:0] rob_id;
  } alu_issue_t;

  typedef struct packed {
    logic [ROB_IDX_W-1:0] rob_id;
    logic [PHY_WIDTH-1:0] prd_s;
    logic [XLEN-1:0]      data;
    logic [XLEN-1:0]      rs1_data;
    logic [XLEN-1:0]      rs2_data;
  } alu_cdb_t;

  function automatic logic [XLEN-1:0] alu_f(input alu_ops_t op,
                                            input logic [XLEN-1:0] a,
                                            input logic [XLEN-1:0] b);
    logic [4:0] sh;
    sh = b[4:0];
    case (op)
      alu_add: alu_f = a + b;
      alu_sll: alu_f = a << sh;
      alu_sra: alu_f = XLEN'($signed(a) >>> sh);
      alu_sub: alu_f = a - b;
      alu_xor: alu_f = a ^ b;
      alu_srl: alu_f = a >> sh;
      alu_or:  alu_f = a | b;
      alu_and: alu_f = a & b;
      default: alu_f = a + b;
    endcase
  endfunction

  function automatic logic cmp_f(input cmp_ops_t op,
                                 input logic [XLEN-1:0] a,
                                 input logic [XLEN-1:0] b);
    case (op)
      cmp_beq:  cmp_f = (a == b);
      cmp_bne:  cmp_f = (a != b);
      cmp_blt:  cmp_f = ($signed(a) < $signed(b));
      cmp_bge:  cmp_f = ($signed(a) >= $signed(b));
      cmp_bltu: cmp_f = (a < b);
      cmp_bgeu: cmp_f = (a >= b);
      default:  cmp_f = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_result_fifo.sv
// In-order result queue between the execute delay line and the CDB; flush empties it, reset also clears storage.
module alu_result_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter type entry_t = logic
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   flush,
  input  logic   wr_en,
  input  entry_t wr_data,
  input  logic   rd_en,
  output entry_t rd_data_c,
  output logic   full_c,
  output logic   empty_c
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  entry_t             mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q;
  logic [PTR_W-1:0]   rd_ptr_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               wr_ok_c;
  logic               rd_ok_c;

  assign full_c    = (cnt_q == CNT_W'(DEPTH));
  assign empty_c   = (cnt_q == '0);
  assign rd_data_c = mem_q[rd_ptr_q];
  assign rd_ok_c   = rd_en & ~empty_c;
  // A write into a full queue is only accepted when the head leaves in the same cycle.
  assign wr_ok_c   = wr_en & (~full_c | rd_ok_c);

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    ptr_inc = (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (wr_ok_c) begin
        mem_q[wr_ptr_q] <= wr_data;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (rd_ok_c) rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({wr_ok_c, rd_ok_c})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/alu_exec_pipe.sv
// Pipelined integer execute unit: PRF operand read, ALU in the issue cycle, delay line, in-order CDB queue.
module alu_exec_pipe
  import alu_exec_pipe_pkg::*;
#(
  parameter int unsigned PIPE_STAGES = 2,
  parameter int unsigned OUT_DEPTH   = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 issue_valid,
  output logic                 issue_ready,
  input  alu_issue_t           issue_uop,
  output logic                 prf_rd_en,
  output logic [PHY_WIDTH-1:0] ps1_s,
  output logic [PHY_WIDTH-1:0] ps2_s,
  input  logic [XLEN-1:0]      ps1_data,
  input  logic [XLEN-1:0]      ps2_data,
  input  logic                 flush,
  output logic                 cdb_valid,
  input  logic                 cdb_ready,
  output alu_cdb_t             cdb_out
);

  localparam int unsigned IF_W = $clog2(OUT_DEPTH + 1);
  localparam int unsigned DLY  = PIPE_STAGES - 1;

  logic            fire_in_c;
  logic            fire_out_c;
  logic [IF_W-1:0] in_flight_q;
  logic [IF_W-1:0] in_flight_d;
  logic            is_lui_c;
  logic            is_auipc_c;
  logic            b_is_imm_c;
  logic [XLEN-1:0] opnd_a_c;
  logic [XLEN-1:0] opnd_b_c;
  alu_ops_t        aluop_c;
  cmp_ops_t        cmpop_c;
  alu_cdb_t        res_c;
  logic            wr_vld_c;
  alu_cdb_t        wr_data_c;
  logic            empty_c;
  logic            unused_full_c;
  logic            unused_funct7_c;

  assign fire_in_c  = issue_valid & issue_ready & ~flush;
  assign fire_out_c = cdb_valid & cdb_ready;

  assign prf_rd_en = issue_valid;
  assign ps1_s     = issue_uop.pr1_s;
  assign ps2_s     = issue_uop.imm_val[XLEN] ? '0 : issue_uop.pr2_s;

  assign unused_funct7_c = ^{issue_uop.funct7[6], issue_uop.funct7[4:0]};

  // Operand selection, op decode and result formation for the uop being issued.
  always_comb begin
    is_lui_c   = (issue_uop.opcode == OP_LUI);
    is_auipc_c = (issue_uop.opcode == OP_AUIPC);
    b_is_imm_c = issue_uop.imm_val[XLEN] | is_lui_c | is_auipc_c;
    opnd_a_c   = ps1_data;
    opnd_b_c   = ps2_data;
    aluop_c    = alu_add;
    cmpop_c    = cmp_blt;
    if (is_auipc_c) opnd_a_c = issue_uop.pc;
    if (is_lui_c)   opnd_a_c = '0;
    if (b_is_imm_c) opnd_b_c = issue_uop.imm_val[XLEN-1:0];
    case (issue_uop.funct3)
      f3_add:  aluop_c = (issue_uop.funct7[5] & ~issue_uop.imm_val[XLEN]) ? alu_sub : alu_add;
      f3_sr:   aluop_c = issue_uop.funct7[5] ? alu_sra : alu_srl;
      f3_slt:  cmpop_c = cmp_blt;
      f3_sltu: cmpop_c = cmp_bltu;
      default: aluop_c = alu_ops_t'(issue_uop.funct3);
    endcase
    if (is_lui_c | is_auipc_c) aluop_c = alu_add;

    res_c          = '0;
    res_c.rob_id   = issue_uop.rob_id;
    res_c.prd_s    = issue_uop.prd_s;
    res_c.rs1_data = (is_lui_c | is_auipc_c) ? '0 : ps1_data;
    res_c.rs2_data = b_is_imm_c ? '0 : ps2_data;
    if (!(is_lui_c | is_auipc_c) &&
        (issue_uop.funct3 == f3_slt || issue_uop.funct3 == f3_sltu))
      res_c.data = {{(XLEN-1){1'b0}}, cmp_f(cmpop_c, opnd_a_c, opnd_b_c)};
    else
      res_c.data = alu_f(aluop_c, opnd_a_c, opnd_b_c);
  end

  // Credit counter: everything in the delay line plus the queue.
  always_comb begin
    in_flight_d = in_flight_q;
    if (flush) begin
      in_flight_d = '0;
    end else begin
      case ({fire_in_c, fire_out_c})
        2'b10:   in_flight_d = in_flight_q + IF_W'(1);
        2'b01:   in_flight_d = in_flight_q - IF_W'(1);
        default: in_flight_d = in_flight_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_flight_q <= '0;
      issue_ready <= 1'b1;
    end else begin
      in_flight_q <= in_flight_d;
      issue_ready <= (in_flight_d < IF_W'(OUT_DEPTH));
    end
  end

  for (genvar i = 0; i < DLY; i++) begin : g_stage
    logic     vld_q;
    alu_cdb_t data_q;
    logic     in_vld_c;
    alu_cdb_t in_data_c;
    if (i == 0) begin : g_src
      assign in_vld_c  = fire_in_c;
      assign in_data_c = res_c;
    end else begin : g_src
      assign in_vld_c  = g_stage[i-1].vld_q;
      assign in_data_c = g_stage[i-1].data_q;
    end
    always_ff @(posedge clk) begin
      data_q <= in_data_c;
      if (!rst_n || flush) vld_q <= 1'b0;
      else                 vld_q <= in_vld_c;
    end
  end

  if (DLY == 0) begin : g_wr_direct
    assign wr_vld_c  = fire_in_c;
    assign wr_data_c = res_c;
  end else begin : g_wr_piped
    assign wr_vld_c  = g_stage[DLY-1].vld_q;
    assign wr_data_c = g_stage[DLY-1].data_q;
  end

  alu_result_fifo #(
    .DEPTH   (OUT_DEPTH),
    .entry_t (alu_cdb_t)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .wr_en     (wr_vld_c),
    .wr_data   (wr_data_c),
    .rd_en     (fire_out_c),
    .rd_data_c (cdb_out),
    .full_c    (unused_full_c),
    .empty_c   (empty_c)
  );

  assign cdb_valid = ~empty_c & ~flush;

endmodule

// File: tb/tb_alu_exec_pipe.sv
// Randomised and directed bench for alu_exec_pipe, two configurations driven with the same stimulus.
module tb_alu_exec_pipe;
  import alu_exec_pipe_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 issue_valid;
  alu_issue_t           issue_uop;
  logic [31:0]          ps1_data;
  logic [31:0]          ps2_data;
  logic                 flush;
  logic                 cdb_ready;
  logic [1:0]           issue_ready;
  logic [1:0]           prf_rd_en;
  logic [1:0]           cdb_valid;
  logic [PHY_WIDTH-1:0] ps1_s [2];
  logic [PHY_WIDTH-1:0] ps2_s [2];
  alu_cdb_t             cdb_out [2];

  always #5 clk = ~clk;

  alu_exec_pipe #(.PIPE_STAGES(2), .OUT_DEPTH(2)) u_dut_p2 (
    .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .issue_ready(issue_ready[0]),
    .issue_uop(issue_uop), .prf_rd_en(prf_rd_en[0]), .ps1_s(ps1_s[0]), .ps2_s(ps2_s[0]),
    .ps1_data(ps1_data), .ps2_data(ps2_data), .flush(flush), .cdb_valid(cdb_valid[0]),
    .cdb_ready(cdb_ready), .cdb_out(cdb_out[0]));

  alu_exec_pipe #(.PIPE_STAGES(1), .OUT_DEPTH(4)) u_dut_p1 (
    .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .issue_ready(issue_ready[1]),
    .issue_uop(issue_uop), .prf_rd_en(prf_rd_en[1]), .ps1_s(ps1_s[1]), .ps2_s(ps2_s[1]),
    .ps1_data(ps1_data), .ps2_data(ps2_data), .flush(flush), .cdb_valid(cdb_valid[1]),
    .cdb_ready(cdb_ready), .cdb_out(cdb_out[1]));

  // Reference: one ordered queue per configuration; an entry becomes visible once its due cycle arrives.
  typedef struct {
    alu_cdb_t e;
    int       due;
  } pend_t;

  pend_t pq [2][8];
  int    q_head [2];
  int    q_cnt  [2];
  int    cyc;
  bit    armed;
  bit    after_rst;
  int    n_total;
  int    n_bad;

  function automatic alu_cdb_t ref_exec(input alu_issue_t u, input logic [31:0] d1, input logic [31:0] d2);
    alu_cdb_t    r;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] y;
    bit          upper;
    bit          use_imm;
    upper   = (u.opcode == OP_LUI) || (u.opcode == OP_AUIPC);
    use_imm = u.imm_val[32] || upper;
    a = (u.opcode == OP_AUIPC) ? u.pc : ((u.opcode == OP_LUI) ? 32'd0 : d1);
    b = use_imm ? u.imm_val[31:0] : d2;
    if (upper) y = a + b;
    else begin
      case (u.funct3)
        3'd0:    y = (u.funct7[5] && !u.imm_val[32]) ? a - b : a + b;
        3'd1:    y = a << b[4:0];
        3'd2:    y = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        3'd3:    y = (a < b) ? 32'd1 : 32'd0;
        3'd4:    y = a ^ b;
        3'd5:    y = u.funct7[5] ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
        3'd6:    y = a | b;
        default: y = a & b;
      endcase
    end
    r.rob_id   = u.rob_id;
    r.prd_s    = u.prd_s;
    r.data     = y;
    r.rs1_data = upper ? 32'd0 : d1;
    r.rs2_data = use_imm ? 32'd0 : d2;
    return r;
  endfunction

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic alu_issue_t mk(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                                    input logic [32:0] imm, input logic [31:0] pc, input int rob);
    alu_issue_t u;
    u.opcode  = opc;
    u.funct3  = f3;
    u.funct7  = f7;
    u.imm_val = imm;
    u.pc      = pc;
    u.pr1_s   = PHY_WIDTH'($urandom);
    u.pr2_s   = PHY_WIDTH'($urandom);
    u.prd_s   = PHY_WIDTH'($urandom);
    u.rob_id  = ROB_IDX_W'(rob);
    return u;
  endfunction

  function automatic alu_issue_t rand_uop();
    logic [6:0] opc;
    alu_issue_t u;
    case ($urandom_range(0, 3))
      0:       opc = OP_REG;
      1:       opc = OP_IMM;
      2:       opc = OP_LUI;
      default: opc = OP_AUIPC;
    endcase
    u = mk(opc, 3'($urandom), ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00,
           {opc != OP_REG, 32'($urandom)}, 32'($urandom), int'($urandom_range(0, 31)));
    if ($urandom_range(0, 9) == 0) u.imm_val[32] = ~u.imm_val[32];
    return u;
  endfunction

  function automatic logic [31:0] rand_data();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      default: return 32'($urandom);
    endcase
  endfunction

  // One clock cycle: drive at negedge, compare against the reference, then advance the reference.
  task automatic step(input bit v, input alu_issue_t u, input logic [31:0] d1, input logic [31:0] d2,
                      input bit rdy, input bit fl, input bit rn);
    int          p;
    int          d;
    bit          exp_rdy;
    bit          exp_cv;
    alu_cdb_t    zero_cdb;
    @(negedge clk);
    issue_valid = v;
    issue_uop   = u;
    ps1_data    = d1;
    ps2_data    = d2;
    cdb_ready   = rdy;
    flush       = fl;
    rst_n       = rn;
    #1;
    zero_cdb = '0;
    for (int k = 0; k < 2; k++) begin
      p = (k == 0) ? 2 : 1;
      d = (k == 0) ? 2 : 4;
      exp_rdy = (q_cnt[k] < d);
      exp_cv  = (q_cnt[k] > 0) && (pq[k][q_head[k]].due <= cyc) && !fl;
      if (armed) begin
        check_val($sformatf("c%0d d%0d issue_ready", cyc, k), 128'(issue_ready[k]), 128'(exp_rdy));
        check_val($sformatf("c%0d d%0d cdb_valid", cyc, k), 128'(cdb_valid[k]), 128'(exp_cv));
        check_val($sformatf("c%0d d%0d prf_rd_en", cyc, k), 128'(prf_rd_en[k]), 128'(v));
        check_val($sformatf("c%0d d%0d ps1_s", cyc, k), 128'(ps1_s[k]), 128'(u.pr1_s));
        check_val($sformatf("c%0d d%0d ps2_s", cyc, k), 128'(ps2_s[k]),
                  128'(u.imm_val[32] ? '0 : u.pr2_s));
        if (exp_cv)
          check_val($sformatf("c%0d d%0d cdb_out", cyc, k), 128'(cdb_out[k]), 128'(pq[k][q_head[k]].e));
        if (after_rst)
          check_val($sformatf("c%0d d%0d cdb_out_rst", cyc, k), 128'(cdb_out[k]), 128'(zero_cdb));
      end
      if (!rn || fl) begin
        q_cnt[k]  = 0;
        q_head[k] = 0;
      end else begin
        if (exp_cv && rdy) begin
          q_head[k] = (q_head[k] + 1) % 8;
          q_cnt[k]--;
        end
        if (v && exp_rdy) begin
          pq[k][(q_head[k] + q_cnt[k]) % 8] = '{e: ref_exec(u, d1, d2), due: cyc + p};
          q_cnt[k]++;
        end
      end
    end
    after_rst = !rn;
    if (!rn) armed = 1'b1;
    cyc++;
  endtask

  task automatic idle(input bit rdy, input int n);
    for (int i = 0; i < n; i++) step(1'b0, rand_uop(), rand_data(), rand_data(), rdy, 1'b0, 1'b1);
  endtask

  task automatic run_op(input alu_issue_t u, input logic [31:0] d1, input logic [31:0] d2);
    step(1'b1, u, d1, d2, 1'b1, 1'b0, 1'b1);
    idle(1'b1, 2);
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    cyc     = 0;
    armed   = 1'b0;
    after_rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      q_head[k] = 0;
      q_cnt[k]  = 0;
    end
    rst_n = 1'b0; issue_valid = 1'b0; issue_uop = '0; ps1_data = '0; ps2_data = '0;
    flush = 1'b0; cdb_ready = 1'b0;

    step(1'b0, rand_uop(), 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    idle(1'b1, 1);

    // Basic add with latency, then the individual operations.
    step(1'b1, mk(OP_REG, 3'd0, 7'h00, 33'h0, 32'h0, 3), 32'd5, 32'd7, 1'b1, 1'b0, 1'b1);
    idle(1'b1, 3);
    run_op(mk(OP_REG, 3'd0, 7'h20, 33'h0, 32'h0, 4), 32'd3, 32'd5);
    run_op(mk(OP_IMM, 3'd0, 7'h20, {1'b1, 32'hFFFF_FC00}, 32'h0, 5), 32'h10, 32'h1234);
    run_op(mk(OP_IMM, 3'd5, 7'h20, {1'b1, 32'h0000_0404}, 32'h0, 6), 32'h8000_0000, 32'h0);
    run_op(mk(OP_REG, 3'd2, 7'h00, 33'h0, 32'h0, 7), 32'hFFFF_FFFF, 32'd1);
    run_op(mk(OP_REG, 3'd3, 7'h00, 33'h0, 32'h0, 8), 32'hFFFF_FFFF, 32'd1);
    run_op(mk(OP_AUIPC, 3'd0, 7'h00, {1'b1, 32'h0000_2000}, 32'h1000, 9), 32'h55, 32'h66);
    run_op(mk(OP_LUI, 3'd0, 7'h00, {1'b1, 32'hABCD_E000}, 32'h1000, 10), 32'h55, 32'h66);

    // Backpressure: three back-to-back with the CDB blocked.
    for (int i = 0; i < 3; i++) step(1'b1, rand_uop(), rand_data(), rand_data(), 1'b0, 1'b0, 1'b1);
    idle(1'b0, 2);
    idle(1'b1, 6);

    // Flush with work queued and a uop presented in the flush cycle.
    for (int i = 0; i < 2; i++) step(1'b1, rand_uop(), rand_data(), rand_data(), 1'b0, 1'b0, 1'b1);
    idle(1'b0, 2);
    step(1'b1, rand_uop(), rand_data(), rand_data(), 1'b1, 1'b1, 1'b1);
    idle(1'b1, 4);

    // Reset in the middle of a stream, then a fresh uop.
    for (int i = 0; i < 2; i++) step(1'b1, rand_uop(), rand_data(), rand_data(), 1'b1, 1'b0, 1'b1);
    step(1'b0, rand_uop(), rand_data(), rand_data(), 1'b1, 1'b0, 1'b0);
    idle(1'b1, 1);
    run_op(mk(OP_REG, 3'd4, 7'h00, 33'h0, 32'h0, 11), 32'hF0F0_F0F0, 32'h0FF0_0FF0);

    // Full-throughput stretch followed by random traffic.
    for (int i = 0; i < 20; i++) step(1'b1, rand_uop(), rand_data(), rand_data(), 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 800; i++)
      step($urandom_range(0, 9) < 7, rand_uop(), rand_data(), rand_data(),
           $urandom_range(0, 9) < 6, $urandom_range(0, 99) < 3, $urandom_range(0, 199) != 0);
    idle(1'b1, 6);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
